// File: rtl/genevr_regbank_pkg.sv
// Shared constants and types for the genevr register bank: word map, filler value, FSM states.
package genevr_regbank_pkg;

  localparam int STATUS_IDX = 32;
  localparam int IRQ_EN_IDX = 33;
  localparam int RAW_IDX    = 34;
  localparam int COUNT_BASE = 48;

  localparam logic [31:0] DEAD_VALUE = 32'hdead_beef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/genevr_regbank_if.sv
// Host register-ring request/ack bundle between a host (master) and the register bank (slave).
interface genevr_regbank_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 26
);
  logic                      reg_req_in;
  logic                      reg_rd_wr_L_in;
  logic [AXI_ADDR_WIDTH-1:0] reg_addr_in;
  logic [AXI_DATA_WIDTH-1:0] reg_wr_data;
  logic                      reg_ack_out;
  logic [AXI_DATA_WIDTH-1:0] reg_rd_data;

  modport master (
    output reg_req_in, reg_rd_wr_L_in, reg_addr_in, reg_wr_data,
    input  reg_ack_out, reg_rd_data
  );

  modport slave (
    input  reg_req_in, reg_rd_wr_L_in, reg_addr_in, reg_wr_data,
    output reg_ack_out, reg_rd_data
  );
endinterface

// File: rtl/genevr_event_chan.sv
// One event channel: sticky completion bit (write-1-to-clear) and a saturating event counter.
module genevr_event_chan #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev,
  input  logic             w1c,
  input  logic             clr,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new event always wins over a clear landing in the same cycle.
  always_comb begin
    sticky_d = ev | (sticky_q & ~w1c);
    cnt_d    = cnt_q;
    if (clr) begin
      cnt_d = ev ? CNT_W'(1) : '0;
    end else if (ev && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky = sticky_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/genevr_regbank.sv
// Block-decoded register bank: control registers, per-channel status/counters, maskable irq, one ack per request.
module genevr_regbank
  import genevr_regbank_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 26,
  parameter int REG_ADDR_WIDTH = 8,
  parameter logic [AXI_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_ADDR = 18'h10017,
  parameter int NUM_CTRL_REGS  = 8,
  parameter int NUM_CH         = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  genevr_regbank_if.slave                          bus,
  output logic [AXI_DATA_WIDTH*NUM_CTRL_REGS-1:0]  ctrl_regs,
  output logic [NUM_CTRL_REGS-1:0]                 ctrl_wr_stb,
  input  logic [NUM_CH-1:0]                        ev_pulse,
  output logic                                     irq
);

  localparam int W     = AXI_DATA_WIDTH;
  localparam int IDX_W = REG_ADDR_WIDTH - 2;
  localparam int TAG_W = AXI_ADDR_WIDTH - REG_ADDR_WIDTH;

  state_e                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic [W-1:0]             rd_data_q, rd_data_d;
  logic [W-1:0]             ctrl_q [NUM_CTRL_REGS];
  logic [W-1:0]             ctrl_d [NUM_CTRL_REGS];
  logic [NUM_CTRL_REGS-1:0] ctrl_wr_stb_q, ctrl_wr_stb_d;
  logic [NUM_CH-1:0]        irq_en_q, irq_en_d;
  logic                     irq_q, irq_d;

  logic [NUM_CH-1:0] sticky, w1c, clr;
  logic [W-1:0]      cnt [NUM_CH];
  logic [IDX_W-1:0]  word_idx;
  logic [TAG_W-1:0]  tag;
  logic [W-1:0]      rd_word;
  logic              hit, wr_hit, rd_hit;
  logic [1:0]        unused_addr_lsb;

  assign word_idx        = bus.reg_addr_in[REG_ADDR_WIDTH-1:2];
  assign tag             = bus.reg_addr_in[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign unused_addr_lsb = bus.reg_addr_in[1:0];

  // Requests are only accepted from IDLE, which is what limits each request to a single ack.
  assign hit    = bus.reg_req_in && (tag == BLOCK_ADDR) && (state_q == IDLE);
  assign wr_hit = hit && !bus.reg_rd_wr_L_in;
  assign rd_hit = hit &&  bus.reg_rd_wr_L_in;

  always_comb begin
    ctrl_d        = ctrl_q;
    ctrl_wr_stb_d = '0;
    irq_en_d      = irq_en_q;
    w1c           = '0;
    clr           = '0;
    rd_word       = W'(DEAD_VALUE);
    for (int k = 0; k < NUM_CTRL_REGS; k++) begin
      if (int'(word_idx) == k) begin
        rd_word = ctrl_q[k];
        if (wr_hit) begin
          ctrl_d[k]        = bus.reg_wr_data;
          ctrl_wr_stb_d[k] = 1'b1;
        end
      end
    end
    if (int'(word_idx) == STATUS_IDX) begin
      rd_word = W'(sticky);
      if (wr_hit) w1c = bus.reg_wr_data[NUM_CH-1:0];
    end
    if (int'(word_idx) == IRQ_EN_IDX) begin
      rd_word = W'(irq_en_q);
      if (wr_hit) irq_en_d = bus.reg_wr_data[NUM_CH-1:0];
    end
    if (int'(word_idx) == RAW_IDX) begin
      rd_word = W'(ev_pulse);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(word_idx) == COUNT_BASE + c) begin
        rd_word = cnt[c];
        clr[c]  = wr_hit;
      end
    end
    rd_data_d = rd_hit ? rd_word : rd_data_q;
    ack_d     = hit;
    irq_d     = |(sticky & irq_en_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = bus.reg_req_in ? WAIT : IDLE;
      WAIT:    if (!bus.reg_req_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ack_q         <= 1'b0;
      rd_data_q     <= '0;
      ctrl_wr_stb_q <= '0;
      irq_en_q      <= '0;
      irq_q         <= 1'b0;
      for (int k = 0; k < NUM_CTRL_REGS; k++) ctrl_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      rd_data_q     <= rd_data_d;
      ctrl_wr_stb_q <= ctrl_wr_stb_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
      ctrl_q        <= ctrl_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    genevr_event_chan #(.CNT_W(W)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .ev     (ev_pulse[c]),
      .w1c    (w1c[c]),
      .clr    (clr[c]),
      .sticky (sticky[c]),
      .cnt    (cnt[c])
    );
  end

  for (genvar k = 0; k < NUM_CTRL_REGS; k++) begin : g_ctrl_out
    assign ctrl_regs[W*k +: W] = ctrl_q[k];
  end

  assign bus.reg_ack_out = ack_q;
  assign bus.reg_rd_data = rd_data_q;
  assign ctrl_wr_stb     = ctrl_wr_stb_q;
  assign irq             = irq_q;

endmodule
